ripemd160_block_feeder: RTL and testbench

Producer side of the RIPEMD-160 stage-1 core block interface.
- Accepts a message as a byte stream and packs it into one 512-bit block in the RIPEMD-160 little-endian order.
- Applies the standard padding (0x80, zero fill, 64-bit bit-length) and drives the core's `i_valid`/`block`.
- Waits for the core's `o_valid`, then returns the 160-bit digest on an output handshake.
- Single-block only: messages of 0..55 bytes.

---
 rtl/ripemd160_pkg.sv | 24 ++
 rtl/ripemd160_block_feeder_pad.sv | 26 ++
 rtl/ripemd160_block_feeder.sv | 165 ++++++++++++++++
 tb/tb_ripemd160_block_feeder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ripemd160_pkg.sv
// Shared constants, FSM state type and byte-lane helper for the RIPEMD-160 block feeder.
package ripemd160_pkg;

  localparam int unsigned BLOCK_W       = 512;
  localparam int unsigned DIGEST_W      = 160;
  localparam int unsigned MAX_MSG_BYTES = 55;
  localparam int unsigned LEN_WORD_IDX  = 14;
  localparam int unsigned CNT_W         = 6;
  localparam int unsigned LANE_W        = 9;

  typedef enum logic [2:0] {
    ST_FILL  = 3'd0,
    ST_PAD   = 3'd1,
    ST_HASH  = 3'd2,
    ST_OUT   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Bit offset of message byte n inside the little-endian word-packed block.
  function automatic int unsigned byte_lane(input int unsigned n);
    return 32 * (n / 4) + 8 * (n % 4);
  endfunction

endpackage

// File: rtl/ripemd160_block_feeder_pad.sv
// Combinational builder of the final padded block: 0x80 marker, zero fill, bit length in word 14.
module ripemd160_block_feeder_pad
  import ripemd160_pkg::*;
(
  input  logic [BLOCK_W-1:0] blk_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic [BLOCK_W-1:0] padded_o
);

  localparam int unsigned LEN_LSB = LEN_WORD_IDX * 32;

  always_comb begin
    padded_o = blk_i;
    for (int n = 0; n < int'(MAX_MSG_BYTES) + 1; n++) begin
      if (CNT_W'(n) == count_i) begin
        padded_o[LANE_W'(byte_lane(n)) +: 8] = 8'h80;
      end else if (CNT_W'(n) > count_i) begin
        padded_o[LANE_W'(byte_lane(n)) +: 8] = 8'h00;
      end
    end
    // Message length in bits; messages are short enough that the high length word is always zero.
    padded_o[LEN_LSB +: 32]    = 32'(count_i) << 3;
    padded_o[BLOCK_W-1 -: 32]  = 32'h0;
  end

endmodule

// File: rtl/ripemd160_block_feeder.sv
// Byte-stream to single RIPEMD-160 block feeder with padding and digest handshake.
// Optional HASH-state watchdog enabled by defining RIPEMD_FEEDER_TIMEOUT_EN.
module ripemd160_block_feeder
  import ripemd160_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  input  logic                in_keep,
  input  logic                in_last,
  output logic                in_ready,
  output logic                blk_valid,
  output logic [BLOCK_W-1:0]  blk,
  input  logic                core_done,
  input  logic [DIGEST_W-1:0] core_ans,
  output logic                out_valid,
  output logic [DIGEST_W-1:0] out_digest,
  input  logic                out_ready,
  output logic                err
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [BLOCK_W-1:0]   blk_q, blk_d;
  logic [BLOCK_W-1:0]   padded;
  logic [DIGEST_W-1:0]  digest_q, digest_d;
  logic                 in_ready_q, in_ready_d;
  logic                 blk_valid_q, blk_valid_d;
  logic                 out_valid_q, out_valid_d;
  logic                 err_q, err_d;
  logic                 beat_acc;
  logic [LANE_W-1:0]    wr_lane;

`ifdef RIPEMD_FEEDER_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] timer_q, timer_d;
`endif

  ripemd160_block_feeder_pad u_pad (
    .blk_i    (blk_q),
    .count_i  (count_q),
    .padded_o (padded)
  );

  assign beat_acc = in_valid && in_ready_q;
  assign wr_lane  = LANE_W'(byte_lane(32'(count_q)));

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    blk_d    = blk_q;
    digest_d = digest_q;
    err_d    = 1'b0;
`ifdef RIPEMD_FEEDER_TIMEOUT_EN
    timer_d  = '0;
`endif

    case (state_q)
      ST_FILL: begin
        if (beat_acc) begin
          if (in_keep && (count_q == CNT_W'(MAX_MSG_BYTES))) begin
            err_d   = 1'b1;
            blk_d   = '0;
            count_d = '0;
            state_d = in_last ? ST_FILL : ST_DRAIN;
          end else begin
            if (in_keep) begin
              blk_d[wr_lane +: 8] = in_data;
              count_d             = count_q + CNT_W'(1);
            end
            if (in_last) begin
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (beat_acc && in_last) begin
          state_d = ST_FILL;
          count_d = '0;
        end
      end
      ST_PAD: begin
        blk_d   = padded;
        state_d = ST_HASH;
      end
      ST_HASH: begin
        if (core_done) begin
          digest_d = core_ans;
          state_d  = ST_OUT;
        end
`ifdef RIPEMD_FEEDER_TIMEOUT_EN
        else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          blk_d   = '0;
          count_d = '0;
          state_d = ST_FILL;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      ST_OUT: begin
        if (out_ready) begin
          state_d = ST_FILL;
          count_d = '0;
          blk_d   = '0;
        end
      end
      default: begin
        state_d = ST_FILL;
        count_d = '0;
        blk_d   = '0;
      end
    endcase

    in_ready_d  = (state_d == ST_FILL) || (state_d == ST_DRAIN);
    blk_valid_d = (state_d == ST_HASH);
    out_valid_d = (state_d == ST_OUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      blk_q       <= '0;
      digest_q    <= '0;
      in_ready_q  <= 1'b0;
      blk_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      blk_q       <= blk_d;
      digest_q    <= digest_d;
      in_ready_q  <= in_ready_d;
      blk_valid_q <= blk_valid_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

`ifdef RIPEMD_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  assign in_ready   = in_ready_q;
  assign blk_valid  = blk_valid_q;
  assign blk        = blk_q;
  assign out_valid  = out_valid_q;
  assign out_digest = digest_q;
  assign err        = err_q;

endmodule

// File: tb/tb_ripemd160_block_feeder.sv
// Scoreboard bench for ripemd160_block_feeder: expected blocks/digests queued by stimulus, checked by a monitor.
module tb_ripemd160_block_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_keep, in_last, in_ready;
  logic [7:0]   in_data;
  logic         blk_valid, core_done, out_valid, out_ready, err;
  logic [511:0] blk;
  logic [159:0] core_ans, out_digest;

  int n_cmp = 0;
  int n_err = 0;

  logic [511:0] exp_blk_q[$];
  logic [159:0] exp_dig_q[$];

  logic         stub_en = 1'b1;
  logic [159:0] stub_ans = '0;
  int           stub_wait = 0;

  localparam logic [159:0] YANG_DIG = 160'hcc137364_61c2d89e_e2a640c4_1edf7248_3712052e;
  localparam logic [511:0] YANG_BLK = {32'h0, 32'h58, {11{32'h0}},
                                       32'h80676e61, 32'h59207265, 32'h7473614d};

  ripemd160_block_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_keep    (in_keep),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .blk_valid  (blk_valid),
    .blk        (blk),
    .core_done  (core_done),
    .core_ans   (core_ans),
    .out_valid  (out_valid),
    .out_digest (out_digest),
    .out_ready  (out_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Core stand-in: answers three cycles after blk_valid rises.
  initial begin
    core_done = 1'b0;
    core_ans  = '0;
    forever begin
      @(negedge clk);
      if (core_done) begin
        core_done = 1'b0;
        stub_wait = 0;
      end else if (blk_valid && stub_en) begin
        stub_wait++;
        if (stub_wait == 3) begin
          core_ans  = stub_ans;
          core_done = 1'b1;
        end
      end else begin
        stub_wait = 0;
      end
    end
  end

  // Monitor: checks each new block and each accepted digest against the queues.
  initial begin
    logic prev_bv = 1'b0;
    forever begin
      @(negedge clk);
      if (blk_valid && !prev_bv) begin
        if (exp_blk_q.size() == 0) chk("unexpected_blk_valid", 512'(blk_valid), 512'(0));
        else chk("blk", blk, exp_blk_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_dig_q.size() == 0) chk("unexpected_out_valid", 512'(out_valid), 512'(0));
        else chk("digest", 512'(out_digest), 512'(exp_dig_q.pop_front()));
      end
      prev_bv = blk_valid;
    end
  end

  // Drive one beat at a negedge and return at the negedge after it is accepted.
  task automatic send_beat(input logic [7:0] d, input logic keep, input logic last);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_keep = keep; in_last = last;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("beat_accept_timeout", 512'(in_ready), 512'(1));
    @(negedge clk);
    in_valid = 1'b0; in_keep = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_beat(bytes[i], 1'b1, i == bytes.size() - 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(in_ready && !out_valid && !blk_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("idle_timeout", 512'(0), 512'(1));
  endtask

  function automatic logic [511:0] model_blk(input int len);
    logic [511:0] b = '0;
    for (int n = 0; n < len; n++) b[8*n +: 8] = 8'(n);
    b[8*len +: 8]  = 8'h80;
    b[448 +: 32]   = 32'(len * 8);
    return b;
  endfunction

  initial begin
    logic [7:0] yang[$] = '{8'h4d, 8'h61, 8'h73, 8'h74, 8'h65, 8'h72,
                            8'h20, 8'h59, 8'h61, 8'h6e, 8'h67};
    logic [7:0] seq55[$];
    int t;
    for (int i = 0; i < 55; i++) seq55.push_back(8'(i));

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_keep = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_blk_valid", 512'(blk_valid), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_out_digest", 512'(out_digest), 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    chk("rst_blk", blk, 512'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 512'(in_ready), 512'(1));

    // "Master Yang"
    stub_ans = YANG_DIG;
    exp_blk_q.push_back(YANG_BLK);
    exp_dig_q.push_back(YANG_DIG);
    send_msg(yang);
    wait_idle();

    // Empty message, with beat-to-blk_valid latency
    stub_ans = 160'h0123456789abcdef_fedcba9876543210_55aa55aa;
    exp_blk_q.push_back(512'h80);
    exp_dig_q.push_back(stub_ans);
    send_beat(8'h00, 1'b0, 1'b1);
    chk("empty_pad_cycle_blk_valid", 512'(blk_valid), 512'(0));
    @(negedge clk);
    chk("empty_latency_blk_valid", 512'(blk_valid), 512'(1));
    wait_idle();

    // 55 bytes: largest single-block message
    stub_ans = 160'h1111222233334444555566667777888899990000;
    exp_blk_q.push_back(model_blk(55));
    exp_dig_q.push_back(stub_ans);
    send_msg(seq55);
    @(negedge clk);
    chk("max_w13_b3", 512'(blk[13*32+24 +: 8]), 512'(8'h80));
    chk("max_w14_len", 512'(blk[14*32 +: 32]), 512'(32'h1B8));
    wait_idle();

    // 56 bytes without early last: overflow then drain
    for (int i = 0; i < 55; i++) begin
      send_beat(8'(i), 1'b1, 1'b0);
      if (i == 54) chk("pre_ovf_err", 512'(err), 512'(0));
    end
    send_beat(8'h37, 1'b1, 1'b0);
    chk("ovf_err_pulse", 512'(err), 512'(1));
    chk("ovf_blk_cleared", blk, 512'(0));
    send_beat(8'h38, 1'b1, 1'b0);
    chk("ovf_err_one_cycle", 512'(err), 512'(0));
    send_beat(8'h39, 1'b1, 1'b0);
    send_beat(8'h3a, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovf_no_blk_valid", 512'(blk_valid), 512'(0));
    stub_ans = YANG_DIG;
    exp_blk_q.push_back(YANG_BLK);
    exp_dig_q.push_back(YANG_DIG);
    send_msg(yang);
    wait_idle();

    // Downstream stall on digest
    out_ready = 1'b0;
    stub_ans = 160'hdeadbeef_0badf00d_cafebabe_12345678_9abcdef0;
    exp_blk_q.push_back(YANG_BLK);
    exp_dig_q.push_back(stub_ans);
    send_msg(yang);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    for (int c = 0; c < 10; c++) begin
      chk("stall_out_valid", 512'(out_valid), 512'(1));
      chk("stall_out_digest", 512'(out_digest), 512'(stub_ans));
      chk("stall_in_ready", 512'(in_ready), 512'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle();

    // Reset asserted while in HASH
    stub_en = 1'b0;
    exp_blk_q.push_back(YANG_BLK);
    send_msg(yang);
    t = 0;
    while (!blk_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("hash_reached", 512'(blk_valid), 512'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 512'(in_ready), 512'(0));
    chk("midrst_blk_valid", 512'(blk_valid), 512'(0));
    chk("midrst_out_valid", 512'(out_valid), 512'(0));
    chk("midrst_out_digest", 512'(out_digest), 512'(0));
    chk("midrst_err", 512'(err), 512'(0));
    chk("midrst_blk", blk, 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    stub_en = 1'b1;
    @(negedge clk);
    chk("midrst_release_in_ready", 512'(in_ready), 512'(1));
    stub_ans = YANG_DIG;
    exp_blk_q.push_back(YANG_BLK);
    exp_dig_q.push_back(YANG_DIG);
    send_msg(yang);
    wait_idle();
    repeat (2) @(negedge clk);

    chk("blk_queue_drained", 512'(exp_blk_q.size()), 512'(0));
    chk("dig_queue_drained", 512'(exp_dig_q.size()), 512'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

endmodule
